// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared widths, AXI encodings and FSM state type for the instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_BUS      = 32;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } fetch_state_e;

endpackage

// File: rtl/ifetch_hit_buf.sv
// One-entry fetch buffer {valid, addr, data}; valid is only cleared by reset since
// instruction memory is read-only.
module ifetch_hit_buf
  import inst_axi_rd_bridge_pkg::*;
(
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic [INST_ADDR_BUS-1:0] lookup_addr,
  output logic                     lookup_hit,
  output logic [INST_BUS-1:0]      lookup_data,
  input  logic                     fill_en,
  input  logic [INST_ADDR_BUS-1:0] fill_addr,
  input  logic [INST_BUS-1:0]      fill_data
);

  logic                     valid_q;
  logic [INST_ADDR_BUS-1:0] addr_q;
  logic [INST_BUS-1:0]      data_q;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

  always_comb begin
    lookup_hit  = valid_q && (lookup_addr == addr_q);
    lookup_data = data_q;
  end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// IF-stage fetch responder: one outstanding fetch converted to a single-beat AXI4 read.
// Define IFETCH_HIT_BUF_EN to add a one-entry hit buffer that bypasses AXI on repeat fetches.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned         AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0] AXI_ID   = '0
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic                     ice,
  input  logic [INST_ADDR_BUS-1:0] iaddr,
  input  logic                     flush,
  output logic [INST_BUS-1:0]      inst,
  output logic                     if_data_ok,
  output logic                     bus_err,
  output logic [AXI_ID_W-1:0]      arid,
  output logic [INST_ADDR_BUS-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [AXI_ID_W-1:0]      rid,
  input  logic [INST_BUS-1:0]      rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  fetch_state_e             state_q, state_d;
  logic [INST_ADDR_BUS-1:0] araddr_q, araddr_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic [INST_BUS-1:0]      inst_q, inst_d;
  logic                     ok_q, ok_d;
  logic                     err_q, err_d;
  logic                     drop_q, drop_d;
  logic                     fill_en;
  logic                     buf_hit;
  logic [INST_BUS-1:0]      buf_data;

  // Single-beat reads only: rid and rlast carry no information here.
  logic unused_r;
  assign unused_r = ^{rid, rlast};

`ifdef IFETCH_HIT_BUF_EN
  ifetch_hit_buf u_hit_buf (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .lookup_addr (iaddr),
    .lookup_hit  (buf_hit),
    .lookup_data (buf_data),
    .fill_en     (fill_en),
    .fill_addr   (araddr_q),
    .fill_data   (rdata)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
  logic unused_fill;
  assign unused_fill = fill_en;
`endif

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    inst_d    = inst_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    drop_d    = drop_q;
    fill_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ice && !flush) begin
          if (buf_hit) begin
            inst_d  = buf_data;
            ok_d    = 1'b1;
            state_d = StResp;
          end else begin
            araddr_d  = iaddr;
            arvalid_d = 1'b1;
            state_d   = StAddr;
          end
        end
      end
      StAddr: begin
        if (flush) drop_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StData;
        end
      end
      StData: begin
        if (rvalid) begin
          rready_d = 1'b0;
          // A flush in the completion cycle itself also makes this beat stale.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            inst_d  = rdata;
            ok_d    = 1'b1;
            err_d   = (rresp != AXI_RESP_OKAY);
            fill_en = (rresp == AXI_RESP_OKAY);
            state_d = StResp;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n) begin
      state_q   <= StIdle;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      inst_q    <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      inst_q    <= inst_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign inst       = inst_q;
  assign if_data_ok = ok_q;
  assign bus_err    = err_q;
  assign arid       = AXI_ID;
  assign araddr     = araddr_q;
  assign arlen      = 8'd0;
  assign arsize     = AXI_SIZE_WORD;
  assign arburst    = AXI_BURST_INCR;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge with a small AXI read responder process.
module tb_inst_axi_rd_bridge;

  localparam int unsigned IdW = 4;

  logic            cpu_clk_50M = 1'b0;
  logic            cpu_rst_n;
  logic            ice, flush;
  logic [31:0]     iaddr;
  logic [31:0]     inst;
  logic            if_data_ok, bus_err;
  logic [IdW-1:0]  arid, rid;
  logic [31:0]     araddr, rdata;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, rresp;
  logic            arvalid, arready, rlast, rvalid, rready;

  inst_axi_rd_bridge #(
    .AXI_ID_W (IdW),
    .AXI_ID   (4'd3)
  ) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .ice         (ice),
    .iaddr       (iaddr),
    .flush       (flush),
    .inst        (inst),
    .if_data_ok  (if_data_ok),
    .bus_err     (bus_err),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ar_log[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ar_wait  = 0;
  int          r_wait   = 0;
  logic [1:0]  resp_cfg = 2'b00;
  int          ok_cnt   = 0;
  int          viol     = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h24080001;
      32'hBFC00380: return 32'h40806000;
      default:      return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // AXI responder plus protocol monitor; everything happens on the falling edge.
  task automatic slave();
    int          ar_cnt = 0;
    int          r_cnt = 0;
    bit          r_pend = 0;
    bit          pend_prev = 0;
    logic [31:0] addr_prev = '0;
    logic [31:0] r_addr = '0;
    forever begin
      @(negedge cpu_clk_50M);
      if (if_data_ok) ok_cnt++;
      if (bus_err && !if_data_ok) viol++;
      if (cpu_rst_n) begin
        arready = 1'b0; rvalid = 1'b0; r_pend = 0; ar_cnt = 0; r_cnt = 0; pend_prev = 0;
      end else begin
        if (pend_prev && (!arvalid || araddr !== addr_prev)) viol++;
        if (arready) begin
          arready = 1'b0; r_pend = 1; r_cnt = 0; ar_cnt = 0;
        end else if (arvalid) begin
          if (ar_cnt >= ar_wait) begin
            arready = 1'b1; r_addr = araddr; ar_log.push_back(araddr);
          end else ar_cnt++;
        end
        if (rvalid) rvalid = 1'b0;
        else if (r_pend && rready) begin
          if (r_cnt >= r_wait) begin
            rvalid = 1'b1; rdata = mem_word(r_addr); rresp = resp_cfg; r_pend = 0;
          end else r_cnt++;
        end
        pend_prev = arvalid && !arready;
        addr_prev = araddr;
      end
    end
  endtask

  task automatic start_fetch(input logic [31:0] a);
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = a;
  endtask

  task automatic wait_pulse(input int bound, output bit got, output int cyc);
    got = 0; cyc = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge cpu_clk_50M);
      if (if_data_ok) begin got = 1; cyc = c; break; end
    end
    ice = 1'b0;
  endtask

  task automatic wait_rready(input int bound, output bit seen);
    seen = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge cpu_clk_50M);
      if (rready) begin seen = 1; break; end
    end
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b1; ice = 1'b0; flush = 1'b0; iaddr = '0;
    repeat (3) @(negedge cpu_clk_50M);
    n_checks++; if (arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", arvalid); else n_pass++;
    n_checks++; if (rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", rready); else n_pass++;
    n_checks++; if (if_data_ok !== 1'b0) $display("FAIL rst_ok: got %b want 0", if_data_ok); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus_err); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else n_pass++;
    n_checks++; if (araddr !== 32'h0) $display("FAIL rst_araddr: got %h want 0", araddr); else n_pass++;
    n_checks++; if (arlen !== 8'h0) $display("FAIL arlen: got %h want 00", arlen); else n_pass++;
    n_checks++; if (arsize !== 3'b010) $display("FAIL arsize: got %b want 010", arsize); else n_pass++;
    n_checks++; if (arburst !== 2'b01) $display("FAIL arburst: got %b want 01", arburst); else n_pass++;
    n_checks++; if (arid !== 4'd3) $display("FAIL arid: got %h want 3", arid); else n_pass++;
    cpu_rst_n = 1'b0;
    @(negedge cpu_clk_50M);
  endtask

  task automatic test_basic();
    bit got; int cyc; int ok0; int ar0; exp_t e;
    ar_wait = 0; r_wait = 0; resp_cfg = 2'b00; ok0 = ok_cnt; ar0 = ar_log.size();
    exp_q.push_back({32'h24080001, 1'b0});
    start_fetch(32'hBFC00000);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1) $display("FAIL basic_pulse: got %0d want 1", got); else n_pass++;
    n_checks++; if (cyc != 3) $display("FAIL basic_latency: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL basic_inst: got %h want %h", inst, e.data); else n_pass++;
    n_checks++; if (bus_err !== e.err) $display("FAIL basic_err: got %b want %b", bus_err, e.err); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (if_data_ok !== 1'b0) $display("FAIL basic_onecycle: got %b want 0", if_data_ok); else n_pass++;
    n_checks++; if (ok_cnt - ok0 != 1) $display("FAIL basic_pulses: got %0d want 1", ok_cnt - ok0); else n_pass++;
    n_checks++; if (ar_log.size() - ar0 != 1 || ar_log[ar_log.size()-1] !== 32'hBFC00000)
      $display("FAIL basic_araddr: got %0d ARs last %h want 1 AR to bfc00000",
               ar_log.size() - ar0, ar_log[ar_log.size()-1]); else n_pass++;
  endtask

  task automatic test_stall();
    bit got; int cyc; int v0; int ar0; exp_t e;
    ar_wait = 5; v0 = viol; ar0 = ar_log.size();
    exp_q.push_back({mem_word(32'h80001000), 1'b0});
    start_fetch(32'h80001000);
    wait_pulse(30, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1) $display("FAIL stall_pulse: got %0d want 1", got); else n_pass++;
    n_checks++; if (cyc != 8) $display("FAIL stall_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL stall_inst: got %h want %h", inst, e.data); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (viol != v0) $display("FAIL stall_ar_stable: got %0d violations want 0", viol - v0); else n_pass++;
    n_checks++; if (ar_log.size() - ar0 != 1) $display("FAIL stall_ar_count: got %0d want 1", ar_log.size() - ar0); else n_pass++;
    ar_wait = 0;
  endtask

  task automatic test_flush(input int rw, input logic [31:0] old_a, input logic [31:0] new_a,
                            input string tag);
    bit seen; bit got; int cyc; int ok0; int ar0; exp_t e;
    r_wait = rw; ok0 = ok_cnt; ar0 = ar_log.size();
    exp_q.push_back({mem_word(new_a), 1'b0});
    start_fetch(old_a);
    wait_rready(20, seen);
    flush = 1'b1; iaddr = new_a;
    @(negedge cpu_clk_50M);
    flush = 1'b0;
    wait_pulse(40, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (!seen) $display("FAIL %s_rready: got 0 want 1", tag); else n_pass++;
    n_checks++; if (got !== 1'b1) $display("FAIL %s_pulse: got %0d want 1", tag, got); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL %s_inst: got %h want %h", tag, inst, e.data); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (ok_cnt - ok0 != 1) $display("FAIL %s_pulses: got %0d want 1", tag, ok_cnt - ok0); else n_pass++;
    n_checks++; if (ar_log.size() - ar0 != 2 || ar_log[ar_log.size()-1] !== new_a)
      $display("FAIL %s_reissue: got %0d ARs last %h want 2 last %h", tag,
               ar_log.size() - ar0, ar_log[ar_log.size()-1], new_a); else n_pass++;
    r_wait = 0;
  endtask

  task automatic test_bus_err();
    bit got; int cyc; int v0; exp_t e;
    v0 = viol; resp_cfg = 2'b10;
    exp_q.push_back({mem_word(32'h80003000), 1'b1});
    start_fetch(32'h80003000);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1) $display("FAIL err_pulse: got %0d want 1", got); else n_pass++;
    n_checks++; if (bus_err !== e.err) $display("FAIL err_flag: got %b want %b", bus_err, e.err); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL err_inst: got %h want %h", inst, e.data); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (bus_err !== 1'b0) $display("FAIL err_onecycle: got %b want 0", bus_err); else n_pass++;
    resp_cfg = 2'b00;
    exp_q.push_back({mem_word(32'h80003004), 1'b0});
    start_fetch(32'h80003004);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1 || bus_err !== e.err)
      $display("FAIL okay_err: got pulse %0d err %b want 1 %b", got, bus_err, e.err); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (viol != v0) $display("FAIL err_orphan: got %0d want 0", viol - v0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen; bit got; int cyc; int ok0; exp_t e;
    r_wait = 4; ok0 = ok_cnt;
    start_fetch(32'h80004000);
    wait_rready(20, seen);
    cpu_rst_n = 1'b1; ice = 1'b0;
    @(negedge cpu_clk_50M);
    n_checks++; if (!seen) $display("FAIL mid_rready: got 0 want 1"); else n_pass++;
    n_checks++; if ({arvalid, rready, if_data_ok, bus_err} !== 4'b0)
      $display("FAIL mid_rst_ctrl: got %b want 0000", {arvalid, rready, if_data_ok, bus_err}); else n_pass++;
    n_checks++; if (inst !== 32'h0 || araddr !== 32'h0)
      $display("FAIL mid_rst_data: got inst %h araddr %h want 0 0", inst, araddr); else n_pass++;
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b0; r_wait = 0;
    exp_q.push_back({mem_word(32'h80004010), 1'b0});
    start_fetch(32'h80004010);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1 || cyc != 3)
      $display("FAIL mid_fresh: got pulse %0d latency %0d want 1 3", got, cyc); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL mid_inst: got %h want %h", inst, e.data); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (ok_cnt - ok0 != 1) $display("FAIL mid_pulses: got %0d want 1", ok_cnt - ok0); else n_pass++;
  endtask

  task automatic test_repeat_fetch();
    bit got; int cyc; int ar0; exp_t e;
    int exp_cyc;
    int exp_ars;
`ifdef IFETCH_HIT_BUF_EN
    exp_cyc = 1; exp_ars = 1;
`else
    exp_cyc = 3; exp_ars = 2;
`endif
    ar0 = ar_log.size();
    exp_q.push_back({mem_word(32'h80000000), 1'b0});
    start_fetch(32'h80000000);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1 || inst !== e.data)
      $display("FAIL rep_first: got pulse %0d inst %h want 1 %h", got, inst, e.data); else n_pass++;
    exp_q.push_back({mem_word(32'h80000000), 1'b0});
    start_fetch(32'h80000000);
    wait_pulse(20, got, cyc);
    e = exp_q.pop_front();
    n_checks++; if (got !== 1'b1 || cyc != exp_cyc)
      $display("FAIL rep_latency: got pulse %0d latency %0d want 1 %0d", got, cyc, exp_cyc); else n_pass++;
    n_checks++; if (inst !== e.data) $display("FAIL rep_inst: got %h want %h", inst, e.data); else n_pass++;
    @(negedge cpu_clk_50M);
    n_checks++; if (ar_log.size() - ar0 != exp_ars)
      $display("FAIL rep_ar_count: got %0d want %0d", ar_log.size() - ar0, exp_ars); else n_pass++;
  endtask

  task automatic test_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain: got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = '0; rlast = 1'b1;
    cpu_rst_n = 1'b1; ice = 1'b0; flush = 1'b0; iaddr = '0;
    fork
      slave();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_flush(3, 32'h80002000, 32'hBFC00380, "flush_data");
    test_flush(0, 32'h80002100, 32'h80002200, "flush_last");
    test_bus_err();
    test_reset_mid();
    test_repeat_fetch();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
